seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_scan_ctrl.sv | 83 ++++++++
 tb/tb_seg7_scan_ctrl.sv | 91 +++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment scanner with guard gaps, frame-synchronous value update and leading-zero blanking
module seg7_scan_ctrl #(
   parameter int NDIG  = 4,
   parameter int DIV   = 50000,
   parameter int GUARD = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4*NDIG-1:0] data,
   input  logic              load,
   input  logic              blank_lz,
   output logic              pend,
   output logic [6:0]        hex,
   output logic [NDIG-1:0]   dig
);
   localparam int MAXC = DIV > GUARD ? DIV : GUARD;
   localparam int CW   = $clog2(MAXC + 1);
   localparam int IW   = NDIG > 1 ? $clog2(NDIG) : 1;
   typedef enum logic {S_DRIVE, S_GUARD} state_t;
   state_t            state, nstate;
   logic [CW-1:0]     cnt, ncnt;
   logic [IW-1:0]     idx, nidx;
   logic [4*NDIG-1:0] shadow, nshadow, pending;
   logic              last, wrap, blank;
   logic [3:0]        nnib;
   logic [6:0]        nhex;
   logic [NDIG-1:0]   ndig;
   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'h0: decode = 7'b1000000;
         4'h1: decode = 7'b1111001;
         4'h2: decode = 7'b0100100;
         4'h3: decode = 7'b0110000;
         4'h4: decode = 7'b0011001;
         4'h5: decode = 7'b0010010;
         4'h6: decode = 7'b0000010;
         4'h7: decode = 7'b1011000;
         4'h8: decode = 7'b0000000;
         4'h9: decode = 7'b0010000;
         4'hA: decode = 7'b0001000;
         4'hB: decode = 7'b0000011;
         4'hC: decode = 7'b1000110;
         4'hD: decode = 7'b0100001;
         4'hE: decode = 7'b0000110;
         default: decode = 7'b0001110;
      endcase
   endfunction
   // next slot position, frame-boundary shadow swap, and the outputs that position will show
   always_comb begin
      last    = state == S_DRIVE ? cnt == CW'(DIV - 1) : cnt == CW'(GUARD - 1);
      nstate  = last ? (state == S_DRIVE ? S_GUARD : S_DRIVE) : state;
      ncnt    = last ? '0 : cnt + 1'b1;
      wrap    = last && state == S_GUARD && idx == IW'(NDIG - 1);
      nidx    = last && state == S_GUARD ? (wrap ? '0 : idx + 1'b1) : idx;
      nshadow = wrap && pend ? pending : shadow;
      nnib    = nshadow[4*nidx +: 4];
      blank   = blank_lz && nidx != '0 && (nshadow >> {nidx, 2'b00}) == '0;
      nhex    = nstate == S_DRIVE && !blank ? decode(nnib) : '1;
      ndig    = nstate == S_DRIVE ? ~(NDIG'(1) << nidx) : '1;
   end
   // state, pending/shadow storage and registered display outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_DRIVE;
         cnt     <= '0;
         idx     <= '0;
         shadow  <= '0;
         pending <= '0;
         pend    <= 1'b0;
         hex     <= '1;
         dig     <= '1;
      end else begin
         state   <= nstate;
         cnt     <= ncnt;
         idx     <= nidx;
         shadow  <= nshadow;
         pending <= load ? data : pending;
         pend    <= load | (pend & ~wrap);
         hex     <= nhex;
         dig     <= ndig;
      end
   end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: randomized check of seg7_scan_ctrl against a frame-position reference model
module tb_seg7_scan_ctrl;
   localparam int NDIG = 4, DIV = 4, GUARD = 1;
   localparam int SLOT = DIV + GUARD, FRAME = NDIG * SLOT;
   logic clk = 1'b0, rst = 1'b1, load = 1'b0, blank_lz = 1'b0;
   logic [15:0] data = '0;
   logic pend;
   logic [6:0] hex;
   logic [3:0] dig;
   int checks = 0, failures = 0;
   logic [6:0] seg [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
   int n;
   logic [15:0] m_shadow, m_pending;
   logic m_pend;
   logic [6:0] e_hex;
   logic [3:0] e_dig;

   seg7_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .GUARD(GUARD)) dut (
      .clk(clk), .rst(rst), .data(data), .load(load), .blank_lz(blank_lz),
      .pend(pend), .hex(hex), .dig(dig)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s edge=%0d got=%h exp=%h", tag, n, got, exp);
      end
   endtask

   // model one rising edge using the inputs applied before it
   task automatic model_edge();
      int pos, slot;
      logic wrap, on, blanked;
      if (rst) begin
         n = 0; m_shadow = '0; m_pending = '0; m_pend = 1'b0;
         e_hex = 7'h7f; e_dig = 4'hf;
         return;
      end
      n++;
      wrap = (n % FRAME) == 0;
      if (wrap && m_pend) m_shadow = m_pending;
      m_pend = load ? 1'b1 : (wrap ? 1'b0 : m_pend);
      if (load) m_pending = data;
      pos = n % FRAME;
      slot = pos / SLOT;
      on = (pos % SLOT) < DIV;
      blanked = blank_lz && slot > 0 && (m_shadow >> (4 * slot)) == 0;
      e_dig = on ? ~(4'b1 << slot) : 4'hf;
      e_hex = on && !blanked ? seg[(m_shadow >> (4 * slot)) & 16'hf] : 7'h7f;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("hex", 32'(hex), 32'(e_hex));
      chk("dig", 32'(dig), 32'(e_dig));
      chk("pend", 32'(pend), 32'(m_pend));
   endtask

   function automatic logic [15:0] rnd_data();
      logic [15:0] v = '0;
      for (int i = 0; i < 4; i++)
         v[4*i +: 4] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15));
      return v;
   endfunction

   initial begin
      n = 0;
      @(negedge clk);
      load = 1'b1; data = 16'hffff;
      repeat (3) step();
      load = 1'b0;
      rst = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom_range(0, 599) == 0);
         load = ($urandom_range(0, 7) == 0);
         data = rnd_data();
         if ($urandom_range(0, 29) == 0) blank_lz = ~blank_lz;
         step();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
